// File: rtl/mc_pkg.sv
// Shared constants for the multi-cycle sequencer: opcodes, ALU_Control codes,
// FSM state encoding and write-back select codes.
package mc_pkg;

    localparam logic [3:0] OP_OR   = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_CMP  = 4'd3;
    localparam logic [3:0] OP_ORI  = 4'd4;
    localparam logic [3:0] OP_ADDI = 4'd5;
    localparam logic [3:0] OP_LW   = 4'd6;
    localparam logic [3:0] OP_SW   = 4'd7;
    localparam logic [3:0] OP_BEQ  = 4'd8;
    localparam logic [3:0] OP_BNE  = 4'd9;
    localparam logic [3:0] OP_J    = 4'd10;
    localparam logic [3:0] OP_JAL  = 4'd11;
    localparam logic [3:0] OP_JR   = 4'd12;

    localparam logic [3:0] ALU_OR   = 4'b0000;
    localparam logic [3:0] ALU_ADD  = 4'b0001;
    localparam logic [3:0] ALU_SUB  = 4'b0010;
    localparam logic [3:0] ALU_CMP  = 4'b0011;
    localparam logic [3:0] ALU_PASS = 4'b1010;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_t;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC1 = 2'd2;

    // Opcodes 13..15 are unassigned and stop the machine.
    function automatic logic op_illegal(input logic [3:0] op);
        return op >= 4'd13;
    endfunction

endpackage

// File: rtl/mc_op_decode.sv
// Combinational opcode decoder: maps the latched opcode to ALU control and
// the path the instruction takes after EXEC.
module mc_op_decode
    import mc_pkg::*;
(
    input  logic [3:0] op_q,
    output logic [3:0] alu_ctrl,
    output logic       alu_src_imm,
    output logic       needs_mem,
    output logic       needs_wb,
    output logic [1:0] wb_sel,
    output logic       is_branch,
    output logic       is_jump,
    output logic       illegal
);

    always_comb begin
        alu_ctrl    = ALU_OR;
        alu_src_imm = 1'b0;
        needs_mem   = 1'b0;
        needs_wb    = 1'b0;
        wb_sel      = WB_ALU;
        is_branch   = 1'b0;
        is_jump     = 1'b0;
        illegal     = 1'b0;
        case (op_q)
            OP_OR:   begin alu_ctrl = ALU_OR;  needs_wb = 1'b1; end
            OP_ADD:  begin alu_ctrl = ALU_ADD; needs_wb = 1'b1; end
            OP_SUB:  begin alu_ctrl = ALU_SUB; needs_wb = 1'b1; end
            OP_CMP:  begin alu_ctrl = ALU_CMP; needs_wb = 1'b1; end
            OP_ORI, OP_ADDI: begin
                alu_ctrl    = op_q;
                alu_src_imm = 1'b1;
                needs_wb    = 1'b1;
            end
            OP_LW: begin
                alu_ctrl    = op_q;
                alu_src_imm = 1'b1;
                needs_mem   = 1'b1;
                needs_wb    = 1'b1;
                wb_sel      = WB_MEM;
            end
            OP_SW: begin
                alu_ctrl    = op_q;
                alu_src_imm = 1'b1;
                needs_mem   = 1'b1;
            end
            // Branches compare by subtraction and test the Zero flag.
            OP_BEQ, OP_BNE: begin alu_ctrl = ALU_SUB; is_branch = 1'b1; end
            OP_J:    begin alu_ctrl = ALU_PASS; is_jump = 1'b1; end
            OP_JAL: begin
                alu_ctrl = op_q;
                is_jump  = 1'b1;
                needs_wb = 1'b1;
                wb_sel   = WB_PC1;
            end
            OP_JR:   begin alu_ctrl = op_q; is_jump = 1'b1; end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_sequencer.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB control FSM
// with Moore-decoded datapath strobes and a retired-instruction counter.
module mc_sequencer
    import mc_pkg::*;
#(
    parameter int RET_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             run,
    input  logic [3:0]       opcode,
    input  logic             mem_ready,
    input  logic             alu_zero,
    output logic             alu_en,
    output logic [3:0]       alu_ctrl,
    output logic             alu_src_imm,
    output logic             ir_load,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic             reg_we,
    output logic [1:0]       wb_sel,
    output logic             pc_inc,
    output logic             pc_load,
    output logic             pc_sel,
    output logic             instr_done,
    output logic             halted,
    output logic [RET_W-1:0] retired
);

    state_t     state_q, state_d;
    logic [3:0] op_q;
    logic       retire;
    logic       br_taken;

    logic [3:0] dec_alu_ctrl;
    logic [1:0] dec_wb_sel;
    logic       dec_src_imm, dec_needs_mem, dec_needs_wb;
    logic       dec_is_branch, dec_is_jump, dec_illegal;

    mc_op_decode u_dec (
        .op_q        (op_q),
        .alu_ctrl    (dec_alu_ctrl),
        .alu_src_imm (dec_src_imm),
        .needs_mem   (dec_needs_mem),
        .needs_wb    (dec_needs_wb),
        .wb_sel      (dec_wb_sel),
        .is_branch   (dec_is_branch),
        .is_jump     (dec_is_jump),
        .illegal     (dec_illegal)
    );

    // BEQ (even opcode) takes on Zero, BNE (odd opcode) on not-Zero.
    assign br_taken = dec_is_branch & (alu_zero ^ op_q[0]);

    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        case (state_q)
            ST_IDLE:   if (run) state_d = ST_FETCH;
            ST_FETCH:  if (mem_ready) state_d = ST_DECODE;
            ST_DECODE: state_d = op_illegal(opcode) ? ST_HALT : ST_EXEC;
            ST_EXEC: begin
                if (dec_illegal)        state_d = ST_HALT;
                else if (dec_needs_mem) state_d = ST_MEM;
                else if (dec_needs_wb)  state_d = ST_WB;
                else                    retire  = 1'b1;
            end
            ST_MEM: begin
                if (mem_ready) begin
                    if (dec_needs_wb) state_d = ST_WB;
                    else              retire  = 1'b1;
                end
            end
            ST_WB:     retire  = 1'b1;
            ST_HALT:   state_d = ST_HALT;
            default:   state_d = ST_IDLE;
        endcase
        if (retire) state_d = run ? ST_FETCH : ST_IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            op_q    <= 4'd0;
            retired <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_DECODE) op_q <= opcode;
            if (retire) retired <= retired + {{(RET_W-1){1'b0}}, 1'b1};
        end
    end

    assign instr_done = retire;

    always_comb begin
        alu_en      = 1'b0;
        alu_ctrl    = ALU_OR;
        alu_src_imm = 1'b0;
        ir_load     = 1'b0;
        mem_rd      = 1'b0;
        mem_wr      = 1'b0;
        reg_we      = 1'b0;
        wb_sel      = WB_ALU;
        pc_inc      = 1'b0;
        pc_load     = 1'b0;
        pc_sel      = 1'b0;
        halted      = 1'b0;
        case (state_q)
            ST_FETCH: begin
                mem_rd  = 1'b1;
                ir_load = mem_ready;
                pc_inc  = mem_ready;
            end
            ST_EXEC: begin
                alu_en      = 1'b1;
                alu_ctrl    = dec_alu_ctrl;
                alu_src_imm = dec_src_imm;
                if (dec_is_branch) begin
                    pc_load = br_taken;
                    pc_sel  = br_taken;
                end else if (dec_is_jump) begin
                    pc_load = 1'b1;
                end
            end
            // Only LW and SW reach MEM; LW is the one that writes back.
            ST_MEM: begin
                mem_rd = dec_needs_wb;
                mem_wr = ~dec_needs_wb;
            end
            ST_WB: begin
                reg_we = 1'b1;
                wb_sel = dec_wb_sel;
            end
            ST_HALT: halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mc_sequencer.sv
// Self-checking bench for mc_sequencer: per-cycle output model plus a
// retirement scoreboard (instruction length and retired count).
module tb_mc_sequencer;

    localparam int S_F = 0, S_D = 1, S_E = 2, S_M = 3, S_W = 4, S_H = 5;

    typedef struct {
        int         cycles;
        logic [3:0] ret;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       run = 1'b0;
    logic [3:0] opcode = 4'd0;
    logic       mem_ready = 1'b0;
    logic       alu_zero = 1'b0;
    logic       alu_en, alu_src_imm, ir_load, mem_rd, mem_wr, reg_we;
    logic       pc_inc, pc_load, pc_sel, instr_done, halted;
    logic [3:0] alu_ctrl;
    logic [1:0] wb_sel;
    logic [3:0] retired;
    logic [16:0] outs;

    int   n_chk = 0;
    int   n_pass = 0;
    int   cyc_cnt = 0;
    int   n_done = 0;
    int   done_base;
    bit   chk_pending = 0;
    bit   prev_done = 0;
    logic [3:0] pend_ret = 4'd0;
    logic [3:0] exp_ret = 4'd0;
    exp_t exp_q[$];

    mc_sequencer #(.RET_W(4)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .run         (run),
        .opcode      (opcode),
        .mem_ready   (mem_ready),
        .alu_zero    (alu_zero),
        .alu_en      (alu_en),
        .alu_ctrl    (alu_ctrl),
        .alu_src_imm (alu_src_imm),
        .ir_load     (ir_load),
        .mem_rd      (mem_rd),
        .mem_wr      (mem_wr),
        .reg_we      (reg_we),
        .wb_sel      (wb_sel),
        .pc_inc      (pc_inc),
        .pc_load     (pc_load),
        .pc_sel      (pc_sel),
        .instr_done  (instr_done),
        .halted      (halted),
        .retired     (retired)
    );

    always #5 clk = ~clk;

    assign outs = {alu_en, alu_ctrl, alu_src_imm, ir_load, mem_rd, mem_wr,
                   reg_we, wb_sel, pc_inc, pc_load, pc_sel, instr_done, halted};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    // Expected outputs for one cycle in a given state.
    function automatic logic [16:0] model(int st, logic [3:0] op, logic z, logic rdy);
        logic aen = 0, imm = 0, irl = 0, mrd = 0, mwr = 0, rwe = 0;
        logic pinc = 0, pld = 0, psel = 0, done = 0, hlt = 0, taken;
        logic [3:0] actl = 4'd0;
        logic [1:0] wbs = 2'd0;
        case (st)
            S_F: begin mrd = 1; irl = rdy; pinc = rdy; end
            S_E: begin
                aen  = 1;
                actl = (op == 8 || op == 9) ? 4'b0010 : op;
                imm  = (op >= 4 && op <= 7);
                if (op == 8 || op == 9) begin
                    taken = (op == 8) ? z : !z;
                    pld = taken; psel = taken; done = 1;
                end
                if (op >= 10 && op <= 12) begin pld = 1; done = (op != 11); end
            end
            S_M: begin
                if (op == 6) mrd = 1; else mwr = 1;
                done = (op == 7) && rdy;
            end
            S_W: begin
                rwe = 1; done = 1;
                wbs = (op == 6) ? 2'd1 : (op == 11) ? 2'd2 : 2'd0;
            end
            S_H: hlt = 1;
            default: ;
        endcase
        return {aen, actl, imm, irl, mrd, mwr, rwe, wbs, pinc, pld, psel, done, hlt};
    endfunction

    // Retirement monitor: length since previous retirement and the count after it.
    always @(negedge clk) begin
        cyc_cnt = cyc_cnt + 1;
        if (chk_pending) begin
            chk("sb_retired", 32'(retired), 32'(pend_ret));
            chk_pending = 0;
        end
        if (instr_done) begin
            exp_t e;
            n_done++;
            chk("done_gap", 32'(prev_done), 0);
            if (exp_q.size() == 0) chk("sb_pending", 0, 1);
            else begin
                e = exp_q.pop_front();
                chk("sb_len", 32'(cyc_cnt), 32'(e.cycles));
                pend_ret = e.ret;
                chk_pending = 1;
            end
            cyc_cnt = 0;
        end
        prev_done = instr_done;
    end

    task automatic do_reset();
        @(negedge clk); #1;
        reset_n = 0; run = 0; mem_ready = 0; alu_zero = 0; opcode = 4'd0;
        exp_q.delete(); exp_ret = 4'd0; chk_pending = 0;
        #2;
        chk("rst_outs", 32'(outs), 0);
        chk("rst_retired", 32'(retired), 0);
        @(posedge clk); #1;
        reset_n = 1;
    endtask

    // Called just after a rising edge; leaves just after the rising edge that ends the instruction.
    task automatic run_one(input logic [3:0] op, input logic z, input int fs, input int ms,
                           input bit from_idle, input bit keep_run);
        int   seq[$];
        exp_t e;
        logic rdy;
        for (int k = 0; k <= fs; k++) seq.push_back(S_F);
        seq.push_back(S_D);
        if (op >= 13) begin
            for (int k = 0; k < 20; k++) seq.push_back(S_H);
        end else begin
            seq.push_back(S_E);
            if (op == 6 || op == 7) for (int k = 0; k <= ms; k++) seq.push_back(S_M);
            if (op <= 6 || op == 11) seq.push_back(S_W);
            exp_ret = exp_ret + 4'd1;
            e.cycles = seq.size() + (from_idle ? 1 : 0);
            e.ret = exp_ret;
            exp_q.push_back(e);
        end
        opcode = op;
        alu_zero = z;
        if (from_idle) begin
            run = 1;
            cyc_cnt = 0;
            @(negedge clk);
            chk("idle_outs", 32'(outs), 0);
            @(posedge clk); #1;
        end
        if (!keep_run) run = 0;
        for (int i = 0; i < seq.size(); i++) begin
            if (seq[i] == S_F) rdy = (i == fs);
            else if (seq[i] == S_M) rdy = (i == fs + 3 + ms);
            else rdy = 1'($urandom_range(0, 1));
            mem_ready = rdy;
            @(negedge clk);
            chk($sformatf("op%0d_cyc%0d", op, i), 32'(outs), 32'(model(seq[i], op, z, rdy)));
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        do_reset();

        run_one(4'd1, 0, 0, 0, 1, 0);
        chk("add_retired", 32'(retired), 1);
        run_one(4'd6, 0, 0, 3, 1, 0);
        run_one(4'd8, 1, 0, 0, 1, 0);
        run_one(4'd8, 0, 0, 0, 1, 0);
        run_one(4'd9, 0, 0, 0, 1, 0);
        run_one(4'd9, 1, 0, 0, 1, 0);
        run_one(4'd2, 0, 2, 0, 1, 0);
        run_one(4'd4, 0, 0, 0, 1, 0);
        run_one(4'd7, 0, 0, 1, 1, 0);
        run_one(4'd10, 0, 0, 0, 1, 0);
        run_one(4'd11, 0, 1, 0, 1, 0);
        run_one(4'd12, 0, 0, 0, 1, 0);
        run_one(4'd0, 0, 0, 0, 1, 0);
        run_one(4'd3, 1, 0, 0, 1, 0);
        run_one(4'd5, 0, 0, 0, 1, 0);

        // Illegal opcode: absorbing HALT with run held high.
        run_one(4'd14, 0, 0, 0, 1, 1);
        chk("halt_retired", 32'(retired), 32'(exp_ret));
        do_reset();
        @(negedge clk);
        chk("post_halt_idle", 32'(outs), 0);
        @(posedge clk); #1;

        // Asynchronous reset while SW waits in MEM.
        opcode = 4'd7; alu_zero = 0; mem_ready = 1; run = 1;
        repeat (4) @(posedge clk);
        #1 mem_ready = 0;
        @(negedge clk);
        chk("sw_mem_wr", 32'(mem_wr), 1);
        #1 reset_n = 0;
        #1;
        chk("sw_rst_mem_wr", 32'(mem_wr), 0);
        chk("sw_rst_retired", 32'(retired), 0);
        run = 0;
        @(posedge clk); #1;
        reset_n = 1;

        // 16 back-to-back ADDs wrap the 4-bit counter.
        do_reset();
        done_base = n_done;
        for (int i = 0; i < 16; i++) run_one(4'd1, 0, 0, 0, (i == 0), (i < 15));
        @(negedge clk);
        chk("wrap_retired", 32'(retired), 0);
        chk("wrap_done_count", 32'(n_done - done_base), 16);
        chk("sb_drained", 32'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mc_sequencer.md
# mc_sequencer

Multi-cycle instruction sequencer for the processor datapath. It walks each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the ALU's `ALU_Control` and `EN` in EXEC. It also generates memory, register-file and PC control strobes and counts retired instructions. It sits between the instruction register and the datapath; it owns no data, only control.

## Interface
- `RET_W`, default 16: width of the retired-instruction counter.
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `run` in 1: level; allows leaving IDLE and starting a new FETCH.
- `opcode` in 4: IR[31:28]; valid from DECODE onward.
- `mem_ready` in 1: memory done; qualifies FETCH and MEM.
- `alu_zero` in 1: ALU `Zero` flag, sampled in EXEC.
- `alu_en` out 1: drives ALU `EN`.
- `alu_ctrl` out 4: drives ALU `ALU_Control`.
- `alu_src_imm` out 1: selects immediate as ALU B.
- `ir_load` out 1: IR write enable.
- `mem_rd`, `mem_wr` out 1 each: memory strobes.
- `reg_we` out 1: register-file write.
- `wb_sel` out 2: 0 = ALU, 1 = MEM, 2 = PC+1.
- `pc_inc` out 1: PC ← PC+1.
- `pc_load` out 1: PC ← target.
- `pc_sel` out 1: target select, 0 = ALU Y, 1 = branch adder.
- `instr_done` out 1: one-cycle pulse on retirement.
- `halted` out 1: sticky after an illegal opcode.
- `retired` out RET_W: retired-instruction count.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT. Encoded as a registered state; outputs are Moore-decoded from the state plus `op_q`.
- IDLE: go to FETCH when `run`=1.
- FETCH: `mem_rd`=1. Stall while `mem_ready`=0. On `mem_ready`, assert `ir_load` and `pc_inc` and go to DECODE.
- DECODE: latch `opcode` into `op_q`. Opcode 13–15 goes to HALT; all others go to EXEC.
- EXEC: `alu_en`=1. `alu_ctrl`=`op_q` for 0–7 and 10–12. Branches (8, 9) use `alu_ctrl`=0010 (SUB). `alu_src_imm`=1 for 4–7.
- Paths after EXEC:
  - 0–5 (OR/ADD/SUB/CMP/ORI/ADDI): WB with `wb_sel`=0.
  - 6 LW: MEM then WB with `wb_sel`=1.
  - 7 SW: MEM (`mem_wr`) then retire.
  - 8 BEQ / 9 BNE: branch taken if `alu_zero`=1 (BEQ) or `alu_zero`=0 (BNE). If taken, `pc_load`=1 and `pc_sel`=1 in EXEC. Retire.
  - 10 J / 12 JR: `pc_load`=1 and `pc_sel`=0 in EXEC. Retire.
  - 11 JAL: `pc_load`=1 and `pc_sel`=0 in EXEC, then WB with `wb_sel`=2.
- MEM: `mem_rd` (LW) or `mem_wr` (SW) stays high until `mem_ready`.
- WB: `reg_we`=1 for one cycle. Retire.
- Retire: `instr_done` pulses and `retired` increments, wrapping modulo 2^RET_W. Next state is FETCH if `run`=1, else IDLE.
- HALT: `halted`=1. Absorbing; only reset exits. `run` is ignored.
- `mem_rd` and `mem_wr` are never high together.

## Timing
- Reset (asynchronous, immediate): state=IDLE, `op_q`=0, `retired`=0, `halted`=0. Every output is 0, including `alu_ctrl`=0000 and `wb_sel`=0.
- Reset mid-MEM drops `mem_rd`/`mem_wr` without waiting for a clock. An in-flight instruction is not retired.
- Cycle counts with `mem_ready` tied high:
  - ALU and JAL: 4 (F, D, E, W).
  - LW: 5.
  - SW: 4.
  - Branch, J, JR: 3.
- Each cycle of `mem_ready`=0 in FETCH or MEM adds one cycle.
- `alu_zero` is sampled combinationally in the EXEC cycle. The ALU is combinational on registered operands.
- `instr_done` is asserted in the last state cycle of the instruction. `retired` shows the new value the following cycle.
- Dropping `run` mid-instruction does not abort it; the instruction completes, then the sequencer enters IDLE.

## Structure
- Package `mc_pkg`:
  - opcode constants (OP_OR … OP_JR);
  - ALU_Control encodings (ALU_OR=0000, ALU_ADD=0001, ALU_SUB=0010, ALU_CMP=0011, ALU_PASS=1010);
  - the state enum;
  - `wb_sel` codes.
- Sub-module `mc_op_decode`: combinational, `op_q` → {alu_ctrl, alu_src_imm, needs_mem, needs_wb, wb_sel, is_branch, is_jump, illegal}. The FSM instantiates it once.

## Test plan
- ADD: reset, `run`=1, `mem_ready`=1, `opcode`=1 → states F, D, E, W in 4 cycles. `alu_en`=1 with `alu_ctrl`=0001 in EXEC, `reg_we`=1 in WB, one `instr_done`, `retired`=1.
- LW with `mem_ready`=0 for 3 MEM cycles → `mem_rd` high 4 consecutive MEM cycles, `wb_sel`=1 in WB, 8 cycles total.
- BEQ, `alu_zero`=1 → `pc_load`=1, `pc_sel`=1, `alu_ctrl`=0010, 3 cycles. Repeat with `alu_zero`=0 → `pc_load` stays 0.
- `opcode`=14 → HALT after DECODE, `halted`=1 held for 20 cycles with `run`=1, `retired` unchanged. Deassert `reset_n` → `halted`=0, state IDLE.
- Assert `reset_n`=0 mid-MEM of SW → `mem_wr` falls before the next `clk` edge, `retired` unchanged at 0.
- `RET_W`=4, 16 back-to-back ADDs → `retired` wraps 15→0. `instr_done` pulses 16 times, never two cycles adjacent.
